// File: rtl/chiplib_riscv_plic_target.sv
// PLIC target (hart context) end of the gateway protocol.
// This block arbitrates among the pending, enabled sources that are above the
// context threshold, and drives the external interrupt line to the hart.
// It serves claim and complete requests as one-hot pulses back to the gateways.
//
// Handshake: claim_req is a level that the front-end holds until claim_ack
// pulses for one cycle. claim_id is valid in that cycle and holds until the
// next ack. complete_req is a one-cycle strobe. It is answered one cycle later
// by an irq_complete pulse, or it is silently dropped when the ID is not valid.
module chiplib_riscv_plic_target #(
    parameter  int NumSrc    = 31,
    parameter  int PrioWidth = 3,
    localparam int IdWidth   = $clog2(NumSrc + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NumSrc-1:0]                  irq_pend,
    input  logic [NumSrc-1:0][PrioWidth-1:0]   src_prio,
    input  logic [NumSrc-1:0]                  src_en,
    input  logic [PrioWidth-1:0]               threshold,
    input  logic                               claim_req,
    output logic                               claim_ack,
    output logic [IdWidth-1:0]                 claim_id,
    input  logic                               complete_req,
    input  logic [IdWidth-1:0]                 complete_id,
    output logic [NumSrc-1:0]                  irq_claim,
    output logic [NumSrc-1:0]                  irq_complete,
    output logic                               eip,
    output logic [1:0]                         state_dbg
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACK = 2'd1, SETTLE1 = 2'd2, SETTLE2 = 2'd3} state_t;

    state_t              state;
    logic [IdWidth-1:0]  best_id_d;
    logic [PrioWidth-1:0] best_prio_d;
    logic [IdWidth-1:0]  best_id_q;
    logic [NumSrc-1:0]   claim_onehot;
    logic [NumSrc-1:0]   complete_onehot;

    assign state_dbg = state;

    // Find the highest-priority candidate. A strict > against the running best
    // keeps the lowest ID on ties, because IDs are scanned in ascending order.
    always_comb begin
        best_id_d   = '0;
        best_prio_d = '0;
        for (int i = 0; i < NumSrc; i++) begin
            if (irq_pend[i] && src_en[i] && (src_prio[i] > threshold) &&
                (src_prio[i] > best_prio_d)) begin
                best_prio_d = src_prio[i];
                best_id_d   = IdWidth'(i + 1);
            end
        end
    end

    // Decode the current winner into a gateway select. ID 0 decodes to no bits.
    always_comb begin
        claim_onehot = '0;
        for (int i = 0; i < NumSrc; i++) begin
            if (best_id_q == IdWidth'(i + 1)) claim_onehot[i] = 1'b1;
        end
    end

    // Decode the completion target. ID 0, IDs outside 1..NumSrc and disabled IDs match no bit.
    always_comb begin
        complete_onehot = '0;
        if (complete_req) begin
            for (int i = 0; i < NumSrc; i++) begin
                if ((complete_id == IdWidth'(i + 1)) && src_en[i]) complete_onehot[i] = 1'b1;
            end
        end
    end

    // Register the arbitration result every cycle, which gives one cycle of latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) best_id_q <= '0;
        else     best_id_q <= best_id_d;
    end

    // Completion pulses run independently of the claim FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq_complete <= '0;
        else     irq_complete <= complete_onehot;
    end

    // Claim FSM with registered outputs. eip tracks the registered winner while
    // the FSM is idle, so it is low from the ack cycle through both settle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            claim_ack <= 1'b0;
            claim_id  <= '0;
            irq_claim <= '0;
            eip       <= 1'b0;
        end else begin
            claim_ack <= 1'b0;
            irq_claim <= '0;
            case (state)
                IDLE: begin
                    if (claim_req) begin
                        state     <= ACK;
                        claim_ack <= 1'b1;
                        claim_id  <= best_id_q;
                        irq_claim <= claim_onehot;
                        eip       <= 1'b0;
                    end else begin
                        eip <= (best_id_d != '0);
                    end
                end
                ACK: begin
                    // An empty claim needs no settle time: no gateway was touched.
                    if (claim_id != '0) begin
                        state <= SETTLE1;
                        eip   <= 1'b0;
                    end else begin
                        state <= IDLE;
                        eip   <= (best_id_d != '0);
                    end
                end
                SETTLE1: begin
                    // The gateway drops irq_pend here; arbitration catches up next cycle.
                    state <= SETTLE2;
                    eip   <= 1'b0;
                end
                SETTLE2: begin
                    state <= IDLE;
                    eip   <= (best_id_d != '0);
                end
                default: begin
                    state <= IDLE;
                    eip   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chiplib_riscv_plic_target.sv
// Directed bench for chiplib_riscv_plic_target. Claims and completions push the
// expected results into queues. A negedge monitor pops each queue whenever the
// DUT produces a pulse.
module tb_chiplib_riscv_plic_target;

    localparam int NumSrc    = 31;
    localparam int PrioWidth = 3;
    localparam int IdWidth   = 5;
    localparam logic [1:0] S_IDLE = 2'd0, S_ACK = 2'd1, S_SET1 = 2'd2, S_SET2 = 2'd3;

    logic                             clk;
    logic                             rst;
    logic [NumSrc-1:0]                irq_pend;
    logic [NumSrc-1:0][PrioWidth-1:0] src_prio;
    logic [NumSrc-1:0]                src_en;
    logic [PrioWidth-1:0]             threshold;
    logic                             claim_req;
    logic                             claim_ack;
    logic [IdWidth-1:0]               claim_id;
    logic                             complete_req;
    logic [IdWidth-1:0]               complete_id;
    logic [NumSrc-1:0]                irq_claim;
    logic [NumSrc-1:0]                irq_complete;
    logic                             eip;
    logic [1:0]                       state_dbg;

    int checks = 0;
    int errors = 0;

    logic [IdWidth-1:0] claim_exp_q[$];
    logic [NumSrc-1:0]  cmpl_exp_q[$];

    chiplib_riscv_plic_target #(.NumSrc(NumSrc), .PrioWidth(PrioWidth)) dut (
        .clk          (clk),
        .rst          (rst),
        .irq_pend     (irq_pend),
        .src_prio     (src_prio),
        .src_en       (src_en),
        .threshold    (threshold),
        .claim_req    (claim_req),
        .claim_ack    (claim_ack),
        .claim_id     (claim_id),
        .complete_req (complete_req),
        .complete_id  (complete_id),
        .irq_claim    (irq_claim),
        .irq_complete (irq_complete),
        .eip          (eip),
        .state_dbg    (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [NumSrc-1:0] id_bit(input logic [IdWidth-1:0] id);
        logic [NumSrc-1:0] v;
        v = '0;
        if (id != '0) v[id - 1] = 1'b1;
        return v;
    endfunction

    // Scoreboard monitor: compare each pulse against the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (claim_ack) begin
                if (claim_exp_q.size() == 0) begin
                    chk("claim_unexpected", 32'(claim_id), 32'hffff_ffff);
                end else begin
                    logic [IdWidth-1:0] e;
                    e = claim_exp_q.pop_front();
                    chk("claim_id", 32'(claim_id), 32'(e));
                    chk("irq_claim", 32'(irq_claim), 32'(id_bit(e)));
                end
            end else if (irq_claim != '0) begin
                chk("irq_claim_stray", 32'(irq_claim), 32'h0);
            end
            if (irq_complete != '0) begin
                if (cmpl_exp_q.size() == 0) begin
                    chk("irq_complete_stray", 32'(irq_complete), 32'h0);
                end else begin
                    chk("irq_complete", 32'(irq_complete), 32'(cmpl_exp_q.pop_front()));
                end
            end
        end
    end

    // Driver: one claim transaction, including the gateway dropping its pending bit.
    task automatic do_claim(input logic [IdWidth-1:0] exp_id);
        claim_req = 1'b1;
        claim_exp_q.push_back(exp_id);
        tick();
        chk("claim_ack_pulse", 32'(claim_ack), 32'h1);
        chk("eip_in_ack", 32'(eip), 32'h0);
        chk("state_ack", 32'(state_dbg), 32'(S_ACK));
        claim_req = 1'b0;
        if (exp_id != '0) irq_pend[exp_id - 1] = 1'b0;
        tick();
        chk("claim_ack_low", 32'(claim_ack), 32'h0);
        if (exp_id != '0) begin
            chk("state_settle1", 32'(state_dbg), 32'(S_SET1));
            chk("eip_in_settle1", 32'(eip), 32'h0);
            tick();
            chk("state_settle2", 32'(state_dbg), 32'(S_SET2));
            chk("eip_in_settle2", 32'(eip), 32'h0);
            chk("claim_id_held", 32'(claim_id), 32'(exp_id));
            tick();
        end
        chk("state_idle", 32'(state_dbg), 32'(S_IDLE));
    endtask

    task automatic do_complete(input logic [IdWidth-1:0] id, input logic [NumSrc-1:0] exp);
        complete_req = 1'b1;
        complete_id  = id;
        if (exp != '0) cmpl_exp_q.push_back(exp);
        tick();
        complete_req = 1'b0;
        chk("irq_complete_t1", 32'(irq_complete), 32'(exp));
        tick();
        chk("irq_complete_gone", 32'(irq_complete), 32'h0);
    endtask

    initial begin
        logic [5:0] wide_id;
        rst = 1'b1;
        irq_pend = '0; src_prio = '0; src_en = '1; threshold = '0;
        claim_req = 1'b0; complete_req = 1'b0; complete_id = '0;
        tick();
        chk("rst_eip", 32'(eip), 32'h0);
        chk("rst_claim_ack", 32'(claim_ack), 32'h0);
        chk("rst_claim_id", 32'(claim_id), 32'h0);
        chk("rst_state", 32'(state_dbg), 32'(S_IDLE));
        rst = 1'b0;
        tick();

        // 1: single source, one-cycle eip latency, claim then complete
        src_prio[4] = 3'd3;
        irq_pend[4] = 1'b1;
        #1 chk("eip_before_edge", 32'(eip), 32'h0);
        tick();
        chk("eip_latency", 32'(eip), 32'h1);
        do_claim(5'd5);
        chk("eip_after_claim", 32'(eip), 32'h0);
        do_complete(5'd5, 31'h10);

        // 2: tie goes to lowest ID, then a higher priority wins
        src_prio[2] = 3'd2; src_prio[6] = 3'd2;
        irq_pend[2] = 1'b1; irq_pend[6] = 1'b1;
        tick();
        do_claim(5'd3);
        chk("eip_reasserted", 32'(eip), 32'h1);
        src_prio[8] = 3'd4; irq_pend[8] = 1'b1;
        tick();
        do_claim(5'd9);
        irq_pend[6] = 1'b0;
        tick();

        // 3: priority equal to threshold is not a candidate
        threshold = 3'd2;
        src_prio[3] = 3'd2; irq_pend[3] = 1'b1;
        tick();
        tick();
        chk("eip_at_threshold", 32'(eip), 32'h0);
        do_claim(5'd0);
        irq_pend[3] = 1'b0;
        threshold = 3'd0;

        // 4: invalid completions are ignored, top ID completes
        do_complete(5'd0, '0);
        wide_id = 6'd32;
        do_complete(wide_id[4:0], '0);
        src_en[5] = 1'b0;
        do_complete(5'd6, '0);
        src_en[5] = 1'b1;
        do_complete(5'd31, 31'h4000_0000);

        // 5: claim and complete in the same cycle
        src_prio[7] = 3'd1; irq_pend[7] = 1'b1;
        tick();
        claim_req = 1'b1; claim_exp_q.push_back(5'd8);
        complete_req = 1'b1; complete_id = 5'd2; cmpl_exp_q.push_back(31'h2);
        tick();
        chk("dual_claim_ack", 32'(claim_ack), 32'h1);
        chk("dual_irq_complete", 32'(irq_complete), 32'h2);
        claim_req = 1'b0; complete_req = 1'b0; irq_pend[7] = 1'b0;
        tick(); tick(); tick();
        chk("dual_state_idle", 32'(state_dbg), 32'(S_IDLE));

        // 6: reset in the middle of a claim
        src_prio[9] = 3'd5; irq_pend[9] = 1'b1;
        tick();
        claim_req = 1'b1; claim_exp_q.push_back(5'd10);
        tick();
        claim_req = 1'b0;
        tick();
        chk("pre_rst_state", 32'(state_dbg), 32'(S_SET1));
        rst = 1'b1;
        #1;
        chk("async_rst_state", 32'(state_dbg), 32'(S_IDLE));
        chk("async_rst_claim_id", 32'(claim_id), 32'h0);
        chk("async_rst_eip", 32'(eip), 32'h0);
        chk("async_rst_irq_claim", 32'(irq_claim), 32'h0);
        tick();
        chk("rst_no_ack", 32'(claim_ack), 32'h0);
        rst = 1'b0;
        tick();
        chk("eip_after_rst", 32'(eip), 32'h1);
        do_claim(5'd10);
        tick();

        chk("claim_q_empty", 32'(claim_exp_q.size()), 32'h0);
        chk("cmpl_q_empty", 32'(cmpl_exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
